dmem_arbiter: RTL and testbench

Data-memory arbiter and sequencer between two requesters and the single-write-enable data BRAM. Requester 0 is the CPU data port; requester 1 is a secondary master such as a loader or debug port. The block grants one request at a time and presents it to the BRAM. It absorbs the BRAM's registered read latency and turns byte-strobed stores into read-modify-write sequences, because the BRAM port has only one write-enable bit.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer between two masters and a single-write-enable data BRAM.
// Build option: define DMEM_ARB_RMW_EN to turn byte-strobed stores into read-modify-write sequences.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2,
  localparam int unsigned STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_i,
  input  logic [STRB_W-1:0] m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic [STRB_W-1:0] m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RMW_WR} state_t;

  state_t            state;
  logic              owner;
  logic              last_m1;
  logic              lat_full;
  logic              lat_rmw;
  logic [CNT_W-1:0]  wait_cnt;

  logic              pick_m1;
  logic              grant_c;
  logic              win_full;
  logic [STRB_W-1:0] win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Both pending: the master that did not own the previous access wins.
  assign pick_m1  = m1_req_i & (~m0_req_i | ~last_m1);
  assign grant_c  = reset & (state == IDLE) & (m0_req_i | m1_req_i);
  assign m0_gnt_o = grant_c & ~pick_m1;
  assign m1_gnt_o = grant_c & pick_m1;

  assign win_we    = pick_m1 ? m1_we_i    : m0_we_i;
  assign win_addr  = pick_m1 ? m1_addr_i  : m0_addr_i;
  assign win_wdata = pick_m1 ? m1_wdata_i : m0_wdata_i;

  assign m0_rdata_o = m0_ack_o ? mem_rdata_i : '0;
  assign m1_rdata_o = m1_ack_o ? mem_rdata_i : '0;

`ifdef DMEM_ARB_RMW_EN
  logic [STRB_W-1:0] lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] merged_c;

  assign win_full = (win_we == {STRB_W{1'b1}});

  // Strobed lanes take the store data, the rest keep the word read back from the BRAM.
  always_comb begin
    merged_c = lat_wdata;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (!lat_we[i]) merged_c[8*i +: 8] = mem_rdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_we    <= '0;
      lat_wdata <= '0;
      lat_rmw   <= 1'b0;
    end else if (grant_c) begin
      lat_we    <= win_we;
      lat_wdata <= win_wdata;
      lat_rmw   <= (|win_we) & ~win_full;
    end
  end
`else
  assign win_full = |win_we;
  assign lat_rmw  = 1'b0;
`endif

  // Sequencer: mem_* and acks are registered one cycle ahead of the state that owns them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_m1     <= 1'b1;
      lat_full    <= 1'b0;
      wait_cnt    <= '0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      m0_ack_o    <= 1'b0;
      m1_ack_o    <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            owner      <= pick_m1;
            last_m1    <= pick_m1;
            lat_full   <= win_full;
            mem_addr_o <= win_addr;
            if (win_full) begin
              mem_we_o    <= 1'b1;
              mem_wdata_o <= win_wdata;
              m0_ack_o    <= ~pick_m1;
              m1_ack_o    <= pick_m1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_full) begin
            state <= IDLE;
          end else begin
            wait_cnt <= CNT_W'(READ_LAT - 1);
            if (READ_LAT == 1 && !lat_rmw) begin
              m0_ack_o <= ~owner;
              m1_ack_o <= owner;
            end
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
            if (wait_cnt == CNT_W'(1) && !lat_rmw) begin
              m0_ack_o <= ~owner;
              m1_ack_o <= owner;
            end
`ifdef DMEM_ARB_RMW_EN
          end else if (lat_rmw) begin
            mem_we_o    <= 1'b1;
            mem_wdata_o <= merged_c;
            m0_ack_o    <= ~owner;
            m1_ack_o    <= owner;
            state       <= RMW_WR;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RMW_WR: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a READ_LAT=2 BRAM model; follows DMEM_ARB_RMW_EN if defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_we_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DMEM_ARB_RMW_EN
  localparam logic [31:0] EXP20     = 32'h1122AA44;
  localparam logic [31:0] EXP20_RST = 32'h1122AA44;
`else
  localparam logic [31:0] EXP20     = 32'h0000AA00;
  localparam logic [31:0] EXP20_RST = 32'h000000CC;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_gnt_o   (m0_gnt_o),
    .m0_ack_o   (m0_ack_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_gnt_o   (m1_gnt_o),
    .m1_ack_o   (m1_ack_o),
    .m1_rdata_o (m1_rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_we_o   (mem_we_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // BRAM model: one write enable, two-stage registered read.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q1, rd_q2;
  always_ff @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
    rd_q1 <= mem[mem_addr_o[9:2]];
    rd_q2 <= rd_q1;
  end
  assign mem_rdata_i = rd_q2;

  a_m0_hold: assert property (@(posedge clk) disable iff (!reset) (m0_req && !m0_gnt_o) |=> m0_req)
    else $error("m0 dropped req before gnt");
  a_m1_hold: assert property (@(posedge clk) disable iff (!reset) (m1_req && !m1_gnt_o) |=> m1_req)
    else $error("m1 dropped req before gnt");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
  endtask

  // Waits for the port's gnt, then leaves in the following cycle with its req dropped.
  task automatic wait_gnt(input bit p, input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (p ? m1_gnt_o : m0_gnt_o) begin got = 1'b1; break; end
      next();
    end
    chk({tag, "_gnt"}, 32'(got), 32'd1);
    next();
    if (p) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  // Called in gnt+1; expects the read ack two cycles later.
  task automatic read_done(input bit p, input logic [31:0] exp, input string tag);
    int j;
    bit got = 1'b0;
    for (j = 1; j <= 8; j++) begin
      #1;
      if (p ? m1_ack_o : m0_ack_o) begin got = 1'b1; break; end
      next();
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(j), 32'd3);
    chk({tag, "_rdata"}, p ? m1_rdata_o : m0_rdata_o, exp);
    chk({tag, "_other"}, p ? m0_rdata_o : m1_rdata_o, 32'd0);
    next();
  endtask

  task automatic do_read(input bit p, input logic [31:0] addr, input logic [31:0] exp, input string tag);
    drive(p, 4'h0, addr, 32'd0);
    wait_gnt(p, tag);
    read_done(p, exp, tag);
  endtask

  task automatic do_write(input bit p, input logic [31:0] addr, input logic [31:0] data, input string tag);
    drive(p, 4'hF, addr, data);
    wait_gnt(p, tag);
    #1;
    chk({tag, "_ack"}, 32'(p ? m1_ack_o : m0_ack_o), 32'd1);
    chk({tag, "_we"}, 32'(mem_we_o), 32'd1);
    next();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    next();
    next();
    #1;
    chk({tag, "_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_hs"}, {28'd0, m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o}, 32'd0);
    chk({tag, "_rdata"}, m0_rdata_o | m1_rdata_o, 32'd0);
    next();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n_g, last_c;
    bit g0p, g1p;
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;

    do_reset("rst0");

    // Full write then read back.
    drive(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
    #1;
    chk("fw_gnt", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd2);
    next();
    m0_req = 1'b0;
    #1;
    chk("fw_we", 32'(mem_we_o), 32'd1);
    chk("fw_addr", mem_addr_o, 32'h10);
    chk("fw_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("fw_ack", 32'(m0_ack_o), 32'd1);
    next();
    do_read(1'b0, 32'h10, 32'hDEADBEEF, "rd10");

    // Byte-strobed store onto a known word.
    do_write(1'b1, 32'h20, 32'h11223344, "pre20");
    drive(1'b1, 4'b0010, 32'h20, 32'h0000AA00);
    #1;
    chk("rmw_gnt", 32'(m1_gnt_o), 32'd1);
    next();
    m1_req = 1'b0;
    #1;
`ifdef DMEM_ARB_RMW_EN
    chk("rmw_t1_we", 32'(mem_we_o), 32'd0);
    next(); #1;
    chk("rmw_t2_we", 32'(mem_we_o), 32'd0);
    next(); #1;
    chk("rmw_t3_we", 32'(mem_we_o), 32'd0);
    chk("rmw_t3_ack", 32'(m1_ack_o), 32'd0);
    next(); #1;
    chk("rmw_t4_we", 32'(mem_we_o), 32'd1);
    chk("rmw_t4_addr", mem_addr_o, 32'h20);
    chk("rmw_t4_wdata", mem_wdata_o, 32'h1122AA44);
    chk("rmw_t4_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd1);
`else
    chk("pw_t1_we", 32'(mem_we_o), 32'd1);
    chk("pw_t1_wdata", mem_wdata_o, 32'h0000AA00);
    chk("pw_t1_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd1);
`endif
    next();
    do_read(1'b1, 32'h20, EXP20, "rd20");

    // Round-robin with both masters reading continuously.
    do_reset("rst1");
    drive(1'b0, 4'h0, 32'h10, 32'd0);
    drive(1'b1, 4'h0, 32'h20, 32'd0);
    n_g = 0;
    last_c = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (m0_gnt_o || m1_gnt_o) begin
        chk("rr_order", 32'(m1_gnt_o), 32'(n_g % 2));
        if (n_g > 0) chk("rr_gap", 32'(c - last_c), 32'd4);
        last_c = c;
        n_g++;
      end
      if (m0_ack_o) begin
        chk("rr_rd0", m0_rdata_o, 32'hDEADBEEF);
        chk("rr_iso1", {31'd0, m1_ack_o} | m1_rdata_o, 32'd0);
      end
      if (m1_ack_o) begin
        chk("rr_rd1", m1_rdata_o, EXP20);
        chk("rr_iso0", {31'd0, m0_ack_o} | m0_rdata_o, 32'd0);
      end
      g0p = m0_gnt_o;
      g1p = m1_gnt_o;
      next();
      if (g0p && n_g >= 4) m0_req = 1'b0;
      if (g1p && n_g >= 4) m1_req = 1'b0;
    end
    chk("rr_count", 32'(n_g), 32'd5);

    // Reset in the middle of a byte-strobed store by m1.
    drive(1'b1, 4'b0001, 32'h20, 32'h000000CC);
    #1;
    chk("mr_gnt", 32'(m1_gnt_o), 32'd1);
    next();
    m1_req = 1'b0;
    next();
    reset = 1'b0;
    #1;
    chk("mr_t2_we", 32'(mem_we_o), 32'd0);
    chk("mr_t2_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    next();
    drive(1'b0, 4'h0, 32'h10, 32'd0);
    drive(1'b1, 4'h0, 32'h20, 32'd0);
    #1;
    chk("mr_t3_we", 32'(mem_we_o), 32'd0);
    chk("mr_t3_hs", {28'd0, m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o}, 32'd0);
    chk("mr_t3_addr", mem_addr_o, 32'd0);
    next();
    reset = 1'b1;
    #1;
    chk("mr_first", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd2);
    chk("mr_mem20", mem[8], EXP20_RST);
    next();
    m0_req = 1'b0;
    read_done(1'b0, 32'hDEADBEEF, "mr_rd0");
    wait_gnt(1'b1, "mr_rd1");
    read_done(1'b1, EXP20_RST, "mr_rd1");

    // Re-request in the ack cycle of a full write.
    drive(1'b0, 4'hF, 32'h30, 32'h0BADF00D);
    #1;
    chk("rq_gnt_t0", 32'(m0_gnt_o), 32'd1);
    next();
    drive(1'b0, 4'h0, 32'h30, 32'd0);
    #1;
    chk("rq_ack_t1", 32'(m0_ack_o), 32'd1);
    chk("rq_nognt_t1", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd0);
    next(); #1;
    chk("rq_gnt_t2", {30'd0, m0_gnt_o, m1_gnt_o}, 32'd2);
    next();
    m0_req = 1'b0;
    #1;
    chk("rq_t3", {30'd0, m0_ack_o, m1_gnt_o}, 32'd0);
    next(); #1;
    chk("rq_t4", {30'd0, m0_ack_o, m1_gnt_o}, 32'd0);
    next(); #1;
    chk("rq_ack_t5", {30'd0, m0_ack_o, m1_gnt_o}, 32'd2);
    chk("rq_rdata_t5", m0_rdata_o, 32'h0BADF00D);
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
